// File: rtl/req_arbiter8.sv
// ---------------------------------------------------------------------------
// req_arbiter8
//
// Eight-way request arbiter. Control moves through three states:
// IDLE -> GRANT -> RELEASE -> IDLE.
//   IDLE    : pick one requester; the grant appears one edge later.
//   GRANT   : the owner keeps the grant until it asserts done or drops its
//             request, or until it has held the grant for MAX_HOLD cycles.
//   RELEASE : one empty cycle before the next arbitration.
//
// Optional feature (macro ROUND_ROBIN_EN):
//   undefined : fixed priority, and the highest set request index wins.
//   defined   : rotating priority. The search starts at a pointer and counts
//               down with wrap-around. After index k is granted, the pointer
//               moves to k-1.
//
// Parameters:
//   MAX_HOLD  - maximum number of GRANT cycles before a forced release
//               (1..255)
//
// Ports:
//   clk        in   1  clock; all state changes on its rising edge
//   rst        in   1  asynchronous active-high reset
//   req        in   8  request lines, one per requester
//   done       in   1  the owner releases the resource (used only in GRANT)
//   gnt        out  8  registered one-hot grant
//   gnt_idx    out  3  registered binary index of the owner
//   gnt_valid  out  1  registered, high while gnt is non-zero
//   idle       out  1  the arbiter is in IDLE and no request is pending
//   tmo        out  1  registered one-cycle pulse on a forced release
// ---------------------------------------------------------------------------
module req_arbiter8 #(
    parameter int MAX_HOLD = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] req,
    input  logic       done,
    output logic [7:0] gnt,
    output logic [2:0] gnt_idx,
    output logic       gnt_valid,
    output logic       idle,
    output logic       tmo
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2
    } state_t;

    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    state_t     state;
    logic [7:0] hold_cnt;
    logic [2:0] win_idx;

`ifdef ROUND_ROBIN_EN
    logic [2:0] ptr;
    logic [2:0] cand;
    logic       win_found;

    // Walk down from the pointer with wrap-around. The first set request
    // found along that walk wins.
    always_comb begin
        win_idx   = ptr;
        win_found = 1'b0;
        cand      = ptr;
        for (int i = 0; i < 8; i++) begin
            cand = ptr - 3'(i);
            if (!win_found && req[cand]) begin
                win_idx   = cand;
                win_found = 1'b1;
            end
        end
    end
`else
    // Scan in ascending order so that the last set bit found, which is the
    // highest one, overwrites any earlier match.
    always_comb begin
        win_idx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (req[i]) begin
                win_idx = 3'(i);
            end
        end
    end
`endif

    assign idle = (state == IDLE) && (req == 8'h00);

    // Control state and every registered output live in this one block.
    // A normal release (done, or the owner drops its request) is tested
    // before the hold limit, so when both happen in the same cycle the
    // release counts as normal and no timeout pulse is produced.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            gnt       <= 8'h00;
            gnt_idx   <= 3'd0;
            gnt_valid <= 1'b0;
            tmo       <= 1'b0;
            hold_cnt  <= 8'd0;
`ifdef ROUND_ROBIN_EN
            ptr       <= 3'd7;
`endif
        end else begin
            case (state)
                IDLE: begin
                    tmo <= 1'b0;
                    if (req != 8'h00) begin
                        gnt       <= 8'b1 << win_idx;
                        gnt_idx   <= win_idx;
                        gnt_valid <= 1'b1;
                        hold_cnt  <= 8'd0;
                        state     <= GRANT;
`ifdef ROUND_ROBIN_EN
                        ptr       <= win_idx - 3'd1;
`endif
                    end
                end

                GRANT: begin
                    if (done || !req[gnt_idx]) begin
                        gnt       <= 8'h00;
                        gnt_idx   <= 3'd0;
                        gnt_valid <= 1'b0;
                        tmo       <= 1'b0;
                        state     <= RELEASE;
                    end else if (hold_cnt == HOLD_LAST) begin
                        gnt       <= 8'h00;
                        gnt_idx   <= 3'd0;
                        gnt_valid <= 1'b0;
                        tmo       <= 1'b1;
                        state     <= RELEASE;
                    end else if (hold_cnt != 8'hFF) begin
                        hold_cnt  <= hold_cnt + 8'd1;
                    end
                end

                RELEASE: begin
                    tmo   <= 1'b0;
                    state <= IDLE;
                end

                default: begin
                    gnt       <= 8'h00;
                    gnt_idx   <= 3'd0;
                    gnt_valid <= 1'b0;
                    tmo       <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_req_arbiter8.sv
// ---------------------------------------------------------------------------
// tb_req_arbiter8
//
// Self-checking bench for req_arbiter8, built with MAX_HOLD = 4.
//   - A behavioural model tracks the current owner, how many grant cycles
//     it has held, and the single release cycle. One process compares every
//     DUT output against this model after each rising edge.
//   - Directed sequences pin the model with hand-computed literal values:
//     first grant, back-to-back grants, timeout, done at the timeout
//     boundary, request hand-over, and asynchronous reset.
//   - A randomized phase then exercises mixed traffic and occasional resets.
// ---------------------------------------------------------------------------
module tb_req_arbiter8;

    localparam int HOLD = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] req;
    logic       done;
    logic [7:0] gnt;
    logic [2:0] gnt_idx;
    logic       gnt_valid;
    logic       idle;
    logic       tmo;

    int vectors     = 0;
    int miscompares = 0;

    // Model state: current owner index (-1 when there is none), the number
    // of grant cycles the owner has completed, whether the one-cycle release
    // gap is in progress, the expected timeout pulse, and the rotating
    // priority pointer.
    int mOwner   = -1;
    int mHeld    = 0;
    bit mRelease = 1'b0;
    bit mTmo     = 1'b0;
    int mPtr     = 7;

    logic [7:0] sReq;
    logic       sDone;
    logic       sRst;

    req_arbiter8 #(.MAX_HOLD(HOLD)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .done      (done),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid),
        .idle      (idle),
        .tmo       (tmo)
    );

    // The clock has a 10-time-unit period. Inputs change on the falling
    // edge, so they are stable when the next rising edge samples them.
    always #5 clk = ~clk;

    // Each call to this task is one comparison. A mismatch prints a FAIL
    // line and the run continues.
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t",
                     name, actual, expected, $time);
        end
    endtask

    // Drives the request and done inputs with blocking assignments.
    task automatic applyStimulus(input logic [7:0] r, input logic d);
        req  = r;
        done = d;
    endtask

    // Chooses the winner directly from the priority rule for the active
    // mode. Returns -1 when no request is set.
    function automatic int pickWinner(input logic [7:0] r, input int ptr);
`ifdef ROUND_ROBIN_EN
        for (int step = 0; step < 8; step++) begin
            int c;
            c = (ptr - step + 8) % 8;
            if (r[c]) return c;
        end
        return -1;
`else
        for (int i = 7; i >= 0; i--) begin
            if (r[i]) return i;
        end
        return -1;
`endif
    endfunction

    // Reference-model step and compare. At each rising edge the model
    // advances on the inputs sampled at that edge. One time unit later every
    // DUT output is compared against what the model says it must be.
    always @(posedge clk) begin
        sReq  = req;
        sDone = done;
        sRst  = rst;
        if (sRst) begin
            mOwner   = -1;
            mHeld    = 0;
            mRelease = 1'b0;
            mTmo     = 1'b0;
            mPtr     = 7;
        end else if (mRelease) begin
            mRelease = 1'b0;
            mTmo     = 1'b0;
        end else if (mOwner >= 0) begin
            mHeld = mHeld + 1;
            if (sDone || !sReq[mOwner]) begin
                mOwner   = -1;
                mRelease = 1'b1;
                mTmo     = 1'b0;
            end else if (mHeld == HOLD) begin
                mOwner   = -1;
                mRelease = 1'b1;
                mTmo     = 1'b1;
            end
        end else begin
            mTmo = 1'b0;
            if (sReq != 8'h00) begin
                mOwner = pickWinner(sReq, mPtr);
                mHeld  = 0;
                mPtr   = (mOwner + 7) % 8;
            end
        end
        #1;
        checkOutput("model_gnt", 32'(gnt),
                    (mOwner >= 0) ? (32'd1 << mOwner) : 32'd0);
        checkOutput("model_gnt_idx", 32'(gnt_idx),
                    (mOwner >= 0) ? 32'(mOwner) : 32'd0);
        checkOutput("model_gnt_valid", 32'(gnt_valid), 32'(mOwner >= 0));
        checkOutput("model_tmo", 32'(tmo), 32'(mTmo));
        checkOutput("model_idle", 32'(idle),
                    32'(!mRelease && (mOwner < 0) && (req == 8'h00)));
    end

    // Directed sequences first, then the randomized traffic, then the
    // summary line.
    initial begin
        int cnt;
        int expIdx;
        rst = 1'b1;
        applyStimulus(8'h00, 1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("reset_gnt", 32'(gnt), 32'h00);
        checkOutput("reset_idle", 32'(idle), 32'd1);

        // The first grant appears one edge after the request, and the
        // highest set bit of 8'h05 is index 2.
        applyStimulus(8'h05, 1'b0);
        @(negedge clk);
        checkOutput("first_gnt", 32'(gnt), 32'h04);
        checkOutput("first_idx", 32'(gnt_idx), 32'd2);
        checkOutput("first_valid", 32'(gnt_valid), 32'd1);
        checkOutput("first_idle", 32'(idle), 32'd0);
        applyStimulus(8'h00, 1'b0);
        repeat (3) @(negedge clk);

        // Back-to-back grants with every request held high. done is pulsed
        // in the third grant cycle. The pointer is reset first so that the
        // rotating sequence starts from 7.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(8'hFF, 1'b0);
        @(negedge clk);
        for (int g = 0; g < 9; g++) begin
`ifdef ROUND_ROBIN_EN
            expIdx = (7 - g + 8) % 8;
`else
            expIdx = 7;
`endif
            checkOutput("b2b_valid", 32'(gnt_valid), 32'd1);
            checkOutput("b2b_idx", 32'(gnt_idx), 32'(expIdx));
            checkOutput("b2b_gnt", 32'(gnt), 32'd1 << expIdx);
            repeat (2) @(negedge clk);
            applyStimulus(8'hFF, 1'b1);
            @(negedge clk);
            applyStimulus(8'hFF, 1'b0);
            checkOutput("b2b_release_valid", 32'(gnt_valid), 32'd0);
            checkOutput("b2b_release_tmo", 32'(tmo), 32'd0);
            @(negedge clk);
            checkOutput("b2b_idle_valid", 32'(gnt_valid), 32'd0);
            @(negedge clk);
        end
        applyStimulus(8'h00, 1'b0);
        repeat (3) @(negedge clk);

        // Forced release: the grant is held for exactly HOLD cycles, then
        // tmo pulses for one cycle and the grant is issued again.
        applyStimulus(8'h10, 1'b0);
        @(negedge clk);
        cnt = 0;
        while (gnt_valid && cnt < 20) begin
            cnt++;
            @(negedge clk);
        end
        checkOutput("tmo_hold_cycles", 32'(cnt), 32'(HOLD));
        checkOutput("tmo_pulse", 32'(tmo), 32'd1);
        checkOutput("tmo_gnt_zero", 32'(gnt), 32'h00);
        @(negedge clk);
        checkOutput("tmo_single_cycle", 32'(tmo), 32'd0);
        @(negedge clk);
        checkOutput("tmo_regrant", 32'(gnt), 32'h10);
        applyStimulus(8'h00, 1'b0);
        repeat (3) @(negedge clk);

        // done in the last allowed grant cycle is a normal release.
        applyStimulus(8'h10, 1'b0);
        @(negedge clk);
        repeat (HOLD - 1) @(negedge clk);
        applyStimulus(8'h10, 1'b1);
        @(negedge clk);
        checkOutput("boundary_valid", 32'(gnt_valid), 32'd0);
        checkOutput("boundary_tmo", 32'(tmo), 32'd0);
        applyStimulus(8'h00, 1'b0);
        repeat (2) @(negedge clk);

        // The owner drops its request while a new one rises. The grant is
        // released on the next edge and index 6 is granted two cycles later.
        applyStimulus(8'h08, 1'b0);
        @(negedge clk);
        checkOutput("handover_idx3", 32'(gnt_idx), 32'd3);
        applyStimulus(8'h40, 1'b0);
        @(negedge clk);
        checkOutput("handover_release", 32'(gnt_valid), 32'd0);
        checkOutput("handover_tmo", 32'(tmo), 32'd0);
        @(negedge clk);
        checkOutput("handover_idle", 32'(gnt_valid), 32'd0);
        @(negedge clk);
        checkOutput("handover_gnt6", 32'(gnt), 32'h40);

        // Reset asserted mid-grant drops the grant without waiting for a
        // clock edge. done pulses outside GRANT have no effect.
        #2;
        rst = 1'b1;
        #1;
        checkOutput("async_rst_gnt", 32'(gnt), 32'h00);
        checkOutput("async_rst_valid", 32'(gnt_valid), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            applyStimulus(8'h00, k[0] ? 1'b0 : 1'b1);
            @(negedge clk);
            checkOutput("idle_done_gnt", 32'(gnt), 32'h00);
            checkOutput("idle_done_idle", 32'(idle), 32'd1);
        end

        // Randomized traffic. Requests are often held, so that timeouts can
        // occur, and resets are rare.
        for (int c = 0; c < 600; c++) begin
            int sel;
            sel = int'($urandom_range(0, 9));
            if (sel == 0) begin
                applyStimulus(8'h00, done);
            end else if (sel == 1) begin
                applyStimulus(8'h01 << $urandom_range(0, 7), done);
            end else if (sel == 2) begin
                applyStimulus(8'($urandom), done);
            end
            done = ($urandom_range(0, 5) == 0);
            rst  = ($urandom_range(0, 149) == 0);
            @(negedge clk);
        end
        rst = 1'b0;
        applyStimulus(8'h00, 1'b0);
        repeat (3) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/req_arbiter8.md
REQ_ARBITER8 -- requirements
Module: req_arbiter8

Interface
REQ-001 Parameter MAX_HOLD, default 15, maximum GRANT cycles before a forced release; legal range 1..255.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 req  input  8  request lines, one per requester; bit 7 is highest fixed priority.
REQ-005 done  input  1  the current owner releases the resource; sampled only in GRANT.
REQ-006 gnt  output  8  registered one-hot grant; all-zero when no owner.
REQ-007 gnt_idx  output  3  registered binary index of the granted requester; 3'b000 when no owner.
REQ-008 gnt_valid  output  1  registered, high exactly when gnt is non-zero.
REQ-009 idle  output  1  high when the FSM is in IDLE and req == 8'h00.
REQ-010 tmo  output  1  registered one-cycle pulse on a forced release.

Function
REQ-011 The FSM SHALL have states IDLE, GRANT and RELEASE; no other state is reachable.
REQ-012 IDLE with req == 0: stay in IDLE; gnt, gnt_idx, gnt_valid and tmo stay 0.
REQ-013 IDLE with req != 0: select the winner by priority (REQ-019); on the next edge load gnt and gnt_idx, set gnt_valid, clear the hold counter and enter GRANT. Latency is 1 cycle from req sample to gnt.
REQ-014 GRANT: gnt, gnt_idx and gnt_valid SHALL hold stable; requests from other requesters SHALL be ignored.
REQ-015 GRANT exit, in order of precedence:
  - done == 1, or req[gnt_idx] == 0: normal release.
  - hold counter == MAX_HOLD-1 (grant held MAX_HOLD cycles): forced release; tmo pulses high in the first RELEASE cycle.
  - If a normal release and the timeout occur in the same cycle, it is a normal release and tmo stays 0.
REQ-016 RELEASE: lasts exactly 1 cycle with gnt = 0, gnt_valid = 0 and gnt_idx = 0, then enters IDLE.
REQ-017 Back-to-back grants: the last GRANT cycle is n, RELEASE is n+1, IDLE arbitration is n+2, and the new gnt is visible at n+3.
REQ-018 Hold counter: 8 bits, increments each GRANT cycle, never wraps (it saturates, but the exit occurs first).
REQ-019 Fixed priority: the highest set index of req wins.
REQ-020 done asserted outside GRANT SHALL have no effect.
REQ-021 gnt SHALL never have more than one bit set; gnt[gnt_idx] == gnt_valid at all times.

Reset
REQ-022 rst == 1 SHALL force, asynchronously:
  - state = IDLE
  - gnt = 8'h00, gnt_idx = 3'b000, gnt_valid = 0, tmo = 0
  - hold counter = 0
  - rotation pointer = 7
REQ-023 Reset asserted in GRANT SHALL drop the grant immediately, without passing through RELEASE.
REQ-024 After rst deasserts, the first arbitration occurs on the first rising edge at which req != 0.

Configuration
REQ-025 Macro ROUND_ROBIN_EN.
  - Defined: priority search starts at the pointer ptr and descends with wrap (ptr, ptr-1, ..., 0, 7, ...). After granting index k, ptr becomes (k-1) mod 8. With ptr = 7 after reset, the first arbitration matches fixed priority.
  - Undefined: fixed priority per REQ-019; the pointer logic SHALL be absent.

Verification
REQ-026 Reset then req=8'h05 at cycle 0 -> gnt=8'h04, gnt_idx=2, gnt_valid=1 at cycle 1; idle=0.
REQ-027 req=8'hFF held, done pulsed in the 3rd GRANT cycle -> RELEASE for 1 cycle, then the next grant 2 cycles later.
  - Fixed mode: every grant is gnt=8'h80.
  - ROUND_ROBIN_EN: grant sequence 7,6,5,...,0,7.
REQ-028 MAX_HOLD=4, req=8'h10 held, done=0 -> gnt_valid high for exactly 4 cycles, tmo=1 for 1 cycle, gnt=0, then the grant is re-issued to 4.
REQ-029 In GRANT for index 3, drop req[3] while req[6] rises -> release on the next edge, tmo=0, then grant to 6 per REQ-017.
REQ-030 Assert rst mid-GRANT -> gnt=0, gnt_valid=0 without waiting for clk; done pulses in IDLE cause no output change.
REQ-031 MAX_HOLD=4 with done=1 in the 4th GRANT cycle -> normal release, tmo stays 0.
